// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-unit result FIFOs feeding two registered CDB lanes.
// Define CDB_RR_EN for round-robin grant; otherwise fixed priority from unit 0.
module cdb_arbiter #(
  parameter int UNITS = 4,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int REG_W = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [UNITS-1:0]            res_valid,
  output logic [UNITS-1:0]            res_ready,
  input  logic [UNITS-1:0][XLEN-1:0]  res_data,
  input  logic [UNITS-1:0][REG_W-1:0] res_arn,
  input  logic [UNITS-1:0][REG_W-1:0] res_rrn,
  output logic [1:0]                  cdb_valid,
  output logic [1:0][XLEN-1:0]        cdb_data,
  output logic [1:0][REG_W-1:0]       cdb_arn,
  output logic [1:0][REG_W-1:0]       cdb_rrn
);

  localparam int UW = $clog2(UNITS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = XLEN + 2 * REG_W;

  logic [EW-1:0]               mem [UNITS][DEPTH];
  logic [UNITS-1:0][PW-1:0]    wptr, rptr;
  logic [UNITS-1:0][CW-1:0]    count;
  logic [UNITS-1:0]            push, pop, nonempty;
  logic [UW-1:0]               start, g0, g1;
  logic                        g0v, g1v;
  logic [EW-1:0]               head0, head1;

  function automatic int wrap(input int v);
    return (v >= UNITS) ? v - UNITS : v;
  endfunction

`ifdef CDB_RR_EN
  logic [UW-1:0] rr;
  assign start = rr;
`else
  assign start = '0;
`endif

  // Ready and grant look only at registered occupancy, so no res_* input reaches an output.
  always_comb begin
    for (int i = 0; i < UNITS; i++) begin
      nonempty[i]  = (count[i] != '0);
      res_ready[i] = (count[i] != CW'(DEPTH));
      push[i]      = res_valid[i] && res_ready[i];
    end
  end

  always_comb begin
    g0v = 1'b0;
    g1v = 1'b0;
    g0  = '0;
    g1  = '0;
    for (int k = 0; k < UNITS; k++) begin
      if (nonempty[wrap(int'(start) + k)]) begin
        if (!g0v) begin
          g0v = 1'b1;
          g0  = UW'(wrap(int'(start) + k));
        end else if (!g1v) begin
          g1v = 1'b1;
          g1  = UW'(wrap(int'(start) + k));
        end
      end
    end
    for (int i = 0; i < UNITS; i++) begin
      pop[i] = (g0v && (g0 == UW'(i))) || (g1v && (g1 == UW'(i)));
    end
    head0 = mem[g0][rptr[g0]];
    head1 = mem[g1][rptr[g1]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < UNITS; i++) begin
      if (push[i]) mem[i][wptr[i]] <= {res_data[i], res_arn[i], res_rrn[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      cdb_valid <= '0;
      cdb_data  <= '0;
      cdb_arn   <= '0;
      cdb_rrn   <= '0;
`ifdef CDB_RR_EN
      rr        <= '0;
`endif
    end else begin
      for (int i = 0; i < UNITS; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      // Idle lanes carry zero tags so consumers never match a stale value.
      cdb_valid <= {g1v, g0v};
      {cdb_data[0], cdb_arn[0], cdb_rrn[0]} <= g0v ? head0 : '0;
      {cdb_data[1], cdb_arn[1], cdb_rrn[1]} <= g1v ? head1 : '0;
`ifdef CDB_RR_EN
      if (g0v) rr <= UW'(wrap(int'(g1v ? g1 : g0) + 1));
`endif
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations hand-derived, valid with or without CDB_RR_EN.
module tb_cdb_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        res_valid;
  logic [3:0]        res_ready;
  logic [3:0][31:0]  res_data;
  logic [3:0][5:0]   res_arn;
  logic [3:0][5:0]   res_rrn;
  logic [1:0]        cdb_valid;
  logic [1:0][31:0]  cdb_data;
  logic [1:0][5:0]   cdb_arn;
  logic [1:0][5:0]   cdb_rrn;

  int n_checks = 0;
  int n_errors = 0;
  int idx;
  logic hs;
  logic seen;
  logic [31:0] rcv [$];

  cdb_arbiter #(.UNITS(4), .DEPTH(2), .XLEN(32), .REG_W(6)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_arn(res_arn), .res_rrn(res_rrn),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .cdb_arn(cdb_arn), .cdb_rrn(cdb_rrn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    res_valid = '0;
    res_data  = '0;
    res_arn   = '0;
    res_rrn   = '0;
  endtask

  task automatic set_res(input int u, input logic [31:0] d, input logic [5:0] a, input logic [5:0] r);
    res_valid[u] = 1'b1;
    res_data[u]  = d;
    res_arn[u]   = a;
    res_rrn[u]   = r;
  endtask

  // One comparison per lane over {valid, arn, rrn, data}.
  task automatic lane(input string tag, input int k, input logic v, input logic [31:0] d,
                      input logic [5:0] a, input logic [5:0] r);
    check(tag, 64'({cdb_valid[k], cdb_arn[k], cdb_rrn[k], cdb_data[k]}), 64'({v, a, r, d}));
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held two cycles with every unit presenting.
    idle();
    reset = 1'b0;
    res_valid = 4'hf;
    tick();
    tick();
    check("rst_ready", 64'(res_ready), 64'(4'hf));
    lane("rst_l0", 0, 1'b0, 32'h0, 6'd0, 6'd0);
    lane("rst_l1", 1, 1'b0, 32'h0, 6'd0, 6'd0);
    idle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_quiet", 64'(cdb_valid), 64'(2'b00));
    end

    // Single result: presented one cycle, on lane 0 two edges later, gone the next.
    do_reset();
    set_res(2, 32'hDEADBEEF, 6'd5, 6'd37);
    tick();
    idle();
    tick();
    lane("single_l0", 0, 1'b1, 32'hDEADBEEF, 6'd5, 6'd37);
    lane("single_l1", 1, 1'b0, 32'h0, 6'd0, 6'd0);
    tick();
    lane("single_clr", 0, 1'b0, 32'h0, 6'd0, 6'd0);

    // Dual grant: all four units at once -> {0,1} then {2,3}.
    do_reset();
    for (int u = 0; u < 4; u++) set_res(u, 32'hA0 + 32'(u), 6'(8 + u), 6'(16 + u));
    tick();
    idle();
    tick();
    lane("dual_c1_l0", 0, 1'b1, 32'hA0, 6'd8, 6'd16);
    lane("dual_c1_l1", 1, 1'b1, 32'hA1, 6'd9, 6'd17);
    tick();
    lane("dual_c2_l0", 0, 1'b1, 32'hA2, 6'd10, 6'd18);
    lane("dual_c2_l1", 1, 1'b1, 32'hA3, 6'd11, 6'd19);
    tick();
    check("dual_idle", 64'(cdb_valid), 64'(2'b00));

    // Unit 0 streams, unit 3 pushes once: unit 3 rides lane 1 on its first eligible
    // cycle (also shows the round-robin pointer came back to 0 after the dual test).
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) set_res(0, 32'h100 + 32'(c), 6'd1, 6'd1);
      if (c == 0) set_res(3, 32'h300, 6'd3, 6'd3);
      tick();
      if (c >= 1) begin
        lane("prio_l0", 0, 1'b1, 32'h100 + 32'(c - 1), 6'd1, 6'd1);
        if (c == 1) lane("prio_l1_u3", 1, 1'b1, 32'h300, 6'd3, 6'd3);
        else        lane("prio_l1_idle", 1, 1'b0, 32'h0, 6'd0, 6'd0);
      end
    end
    idle();
    tick();

    // Three-way contention separates round-robin from fixed priority.
    do_reset();
    for (int u = 0; u < 3; u++) set_res(u, 32'hA000_0000 + 32'(u), 6'(u), 6'(20 + u));
    tick();
    idle();
    for (int u = 0; u < 2; u++) set_res(u, 32'hB000_0000 + 32'(u), 6'(u), 6'(30 + u));
    tick();
    idle();
    lane("arb_c1_l0", 0, 1'b1, 32'hA000_0000, 6'd0, 6'd20);
    lane("arb_c1_l1", 1, 1'b1, 32'hA000_0001, 6'd1, 6'd21);
    tick();
`ifdef CDB_RR_EN
    lane("arb_c2_l0", 0, 1'b1, 32'hA000_0002, 6'd2, 6'd22);
    lane("arb_c2_l1", 1, 1'b1, 32'hB000_0000, 6'd0, 6'd30);
    tick();
    lane("arb_c3_l0", 0, 1'b1, 32'hB000_0001, 6'd1, 6'd31);
`else
    lane("arb_c2_l0", 0, 1'b1, 32'hB000_0000, 6'd0, 6'd30);
    lane("arb_c2_l1", 1, 1'b1, 32'hB000_0001, 6'd1, 6'd31);
    tick();
    lane("arb_c3_l0", 0, 1'b1, 32'hA000_0002, 6'd2, 6'd22);
`endif
    lane("arb_c3_l1", 1, 1'b0, 32'h0, 6'd0, 6'd0);

    // Backpressure: units 0/1 hog the lanes while unit 3 pushes three results.
    do_reset();
    idx = 0;
    rcv.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      idle();
      if (cyc < 4) begin
        set_res(0, 32'hC0 + 32'(cyc), 6'd0, 6'd0);
        set_res(1, 32'hC8 + 32'(cyc), 6'd1, 6'd1);
      end
      if (idx < 3) set_res(3, 32'hD0 + 32'(idx), 6'd3, 6'(40 + idx));
      hs = res_valid[3] && res_ready[3];
      tick();
      if (hs) idx++;
      if (cyc == 1) check("bp_full", 64'(res_ready[3]), 64'(1'b0));
`ifndef CDB_RR_EN
      if (cyc == 2) check("bp_hold", 64'(res_ready[3]), 64'(1'b0));
`endif
      for (int k = 0; k < 2; k++)
        if (cdb_valid[k] && cdb_arn[k] == 6'd3) rcv.push_back(cdb_data[k]);
    end
    idle();
    check("bp_accepted", 64'(idx), 64'(3));
    check("bp_count", 64'(rcv.size()), 64'(3));
    for (int i = 0; i < rcv.size() && i < 3; i++)
      check("bp_order", 64'(rcv[i]), 64'(32'hD0 + 32'(i)));

    // Reset mid-flight: buffered results must never appear.
    do_reset();
    for (int u = 0; u < 4; u++) set_res(u, 32'hE0 + 32'(u), 6'(50 + u), 6'(60 + u));
    tick();
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_ready", 64'(res_ready), 64'(4'hf));
    lane("mid_l0", 0, 1'b0, 32'h0, 6'd0, 6'd0);
    lane("mid_l1", 1, 1'b0, 32'h0, 6'd0, 6'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | (|cdb_valid);
    end
    check("mid_quiet", 64'(seen), 64'(1'b0));
    check("mid_ready_after", 64'(res_ready), 64'(4'hf));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
